// File: rtl/mbist_sequencer.sv
// MBIST write-all/read-all-compare sequencer that steps the background decoder's pattern select.
// Latency: one run is 2*depth cycles per pattern plus one drain cycle. Read compares retire one cycle after the read.
// Backpressure: none. A start request while busy is ignored, and holding start high after done chains runs back to back.
module mbist_sequencer #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_PATTERNS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [2:0]            q,
    input  logic [DATA_WIDTH-1:0] data_t,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_q
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [2:0]            Q_LAST    = 3'(NUM_PATTERNS - 1);

    state_t                  state, state_nxt;
    logic [2:0]              q_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic                    start_run;

    logic                    v_d;
    logic [DATA_WIDTH-1:0]   exp_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [2:0]              q_d;

    assign mem_we    = (state == WRITE);
    assign mem_re    = (state == READ);
    assign busy      = (state == WRITE) || (state == READ) || (state == DRAIN);
    assign done      = (state == DONE);
    assign start_run = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        addr_nxt  = mem_addr;
        case (state)
            IDLE, DONE: begin
                q_nxt     = 3'd0;
                addr_nxt  = '0;
                state_nxt = start ? WRITE : IDLE;
            end
            WRITE: begin
                addr_nxt = mem_addr + 1'b1;
                if (mem_addr == ADDR_LAST) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                addr_nxt = mem_addr + 1'b1;
                if (mem_addr == ADDR_LAST) begin
                    if (q == Q_LAST) begin
                        state_nxt = DRAIN;
                    end else begin
                        q_nxt     = q + 3'd1;
                        state_nxt = WRITE;
                    end
                end
            end
            DRAIN: begin
                q_nxt     = 3'd0;
                addr_nxt  = '0;
                state_nxt = DONE;
            end
            default: begin
                q_nxt     = 3'd0;
                addr_nxt  = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            q        <= 3'd0;
            mem_addr <= '0;
        end else begin
            state    <= state_nxt;
            q        <= q_nxt;
            mem_addr <= addr_nxt;
        end
    end

    // Each read is tagged with its own address and pattern, so its compare
    // lands correctly even after the sequencer has moved on to the next pattern or to DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_d    <= 1'b0;
            exp_d  <= '0;
            addr_d <= '0;
            q_d    <= 3'd0;
        end else begin
            v_d <= mem_re;
            if (mem_re) begin
                exp_d  <= data_t;
                addr_d <= mem_addr;
                q_d    <= q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_q    <= 3'd0;
        end else if (start_run) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_q    <= 3'd0;
        end else if (v_d) begin
            // An unknown equality result falls through to the mismatch branch.
            if (mem_rdata == exp_d) begin
                fail <= fail;
            end else begin
                fail <= 1'b1;
                if (!fail) begin
                    fail_addr <= addr_d;
                    fail_q    <= q_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_mbist_sequencer.sv
// Bench for mbist_sequencer: a background decoder model and a 1-cycle RAM with injectable faults.
module tb_mbist_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] q;
    logic [7:0] data_t;
    logic [3:0] mem_addr;
    logic       mem_we, mem_re;
    logic [7:0] mem_rdata = 8'h00;
    logic       busy, done, fail;
    logic [3:0] fail_addr;
    logic [2:0] fail_q;

    int n_checks = 0;
    int n_fail   = 0;

    // 0: no fault, 1: addr 5 bit0 stuck-at-0, 2: addr 15 bit0 flipped when q == fault_q_sel
    int         fault_kind = 0;
    logic [2:0] fault_q_sel = 3'd0;
    logic [7:0] mem [16];

    mbist_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_PATTERNS(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .q(q), .data_t(data_t),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr), .fail_q(fail_q)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (q)
            3'd0:    data_t = 8'hAA;
            3'd1:    data_t = 8'h55;
            3'd2:    data_t = 8'h00;
            3'd3:    data_t = 8'hFF;
            3'd4:    data_t = 8'h0F;
            3'd5:    data_t = 8'h33;
            default: data_t = 8'hC3;
        endcase
    end

    function automatic logic [7:0] corrupt(input logic [3:0] a, input logic [2:0] k, input logic [7:0] d);
        if (fault_kind == 1 && a == 4'd5) return d & 8'hFE;
        if (fault_kind == 2 && a == 4'd15 && k == fault_q_sel) return d ^ 8'h01;
        return d;
    endfunction

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= corrupt(mem_addr, q, data_t);
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // Returns at the first negedge after the start-sampling edge (run cycle 0).
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Waits from run cycle 0 until done, reporting the cycle index at which done was seen.
    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: done not seen after %0d cycles, required at 193", name, cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, fail, mem_we, mem_re, q, mem_addr, fail_addr, fail_q} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b fail=%b we=%b re=%b q=%0d addr=%0d fa=%0d fq=%0d, required all 0",
                     busy, done, fail, mem_we, mem_re, q, mem_addr, fail_addr, fail_q);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_fault_free();
        logic [9:0] got, exp;
        fault_kind = 0;
        pulse_start();
        for (int c = 0; c <= 193; c++) begin
            if (c < 192)
                exp = {1'b1, (c % 32) < 16, (c % 32) >= 16, 3'(c / 32), 4'(c % 16)};
            else if (c == 192)
                exp = {1'b1, 1'b0, 1'b0, 3'd5, 4'd0};
            else
                exp = 10'd0;
            got = {busy, mem_we, mem_re, q, mem_addr};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL seq_cycle%0d: got {busy,we,re,q,addr}=%b, required %b", c, got, exp);
            end
            if (c == 192 || c == 193) begin
                n_checks++;
                if (done !== (c == 193)) begin
                    n_fail++;
                    $display("FAIL done_cycle%0d: got %b, required %b", c, done, c == 193);
                end
            end
            if (c < 193) @(negedge clk);
        end
        n_checks++;
        if (fail !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_fail: got %b, required 0", fail);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_to_idle: got done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_stuck_bit();
        int cyc;
        fault_kind = 1;
        pulse_start();
        repeat (97) @(negedge clk);   // q=3 write phase, first failure already captured
        n_checks++;
        if (fail !== 1'b1 || fail_addr !== 4'd5 || fail_q !== 3'd1) begin
            n_fail++;
            $display("FAIL stuck_mid: got fail=%b addr=%0d q=%0d, required 1 5 1", fail, fail_addr, fail_q);
        end
        wait_done("stuck", cyc);
        n_checks++;
        if (fail !== 1'b1 || fail_addr !== 4'd5 || fail_q !== 3'd1) begin
            n_fail++;
            $display("FAIL stuck_final: got fail=%b addr=%0d q=%0d, required 1 5 1", fail, fail_addr, fail_q);
        end
    endtask

    task automatic test_boundary(input logic [2:0] k);
        int cyc;
        fault_kind = 2;
        fault_q_sel = k;
        pulse_start();
        wait_done("boundary", cyc);
        n_checks++;
        if (cyc != 193) begin
            n_fail++;
            $display("FAIL boundary_len_q%0d: got %0d cycles, required 193", k, cyc);
        end
        n_checks++;
        if (fail !== 1'b1 || fail_addr !== 4'd15 || fail_q !== k) begin
            n_fail++;
            $display("FAIL boundary_q%0d: got fail=%b addr=%0d q=%0d, required 1 15 %0d", k, fail, fail_addr, fail_q, k);
        end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        fault_kind = 0;
        pulse_start();
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 51;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc != 193) begin
            n_fail++;
            $display("FAIL start_ignored: done at cycle %0d, required 193", cyc);
        end
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, mem_we, mem_re, q, mem_addr} !== 10'd0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b we=%b re=%b q=%0d addr=%0d, required all 0",
                     busy, mem_we, mem_re, q, mem_addr);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_idle: got busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_restart_after_fail();
        int cyc;
        fault_kind = 1;
        pulse_start();
        wait_done("prefail", cyc);
        fault_kind = 0;
        @(negedge clk) start = 1'b1;   // state is IDLE here
        @(negedge clk) start = 1'b0;
        n_checks++;
        if (fail !== 1'b0 || fail_addr !== 4'd0 || fail_q !== 3'd0) begin
            n_fail++;
            $display("FAIL restart_clear: got fail=%b addr=%0d q=%0d, required 0 0 0", fail, fail_addr, fail_q);
        end
        wait_done("restart", cyc);
        n_checks++;
        if (done !== 1'b1 || fail !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_final: got done=%b fail=%b, required 1 0", done, fail);
        end
    endtask

    initial begin
        test_reset();
        test_fault_free();
        test_stuck_bit();
        test_boundary(3'd2);
        test_boundary(3'd5);
        test_start_while_busy();
        test_reset_mid_run();
        test_restart_after_fail();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
